// File: rtl/ram_shim_reader.sv
// Raster RAM read shim: fetches one signed sample as two RAM words,
// low word first, and presents the reassembled sample to the consumer.
module ram_shim_reader #(
  parameter int                 RAM_WID      = 32,
  parameter logic [RAM_WID-1:0] BASE_ADDR    = 32'h1000000,
  parameter int                 MAX_BYTE_WID = 13,
  parameter int                 DAT_WID      = 24,
  parameter int                 RAM_WORD     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch,
  input  logic                rewind,
  output logic [DAT_WID-1:0]  data,
  output logic                finished,
  output logic [RAM_WID-1:0]  addr,
  output logic                read,
  input  logic [RAM_WORD-1:0] word,
  input  logic                valid
);

  localparam int HW = DAT_WID - RAM_WORD;
  localparam logic [MAX_BYTE_WID-1:0] STEP =
    MAX_BYTE_WID'(RAM_WORD / 8);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    GAP,
    RD_HI,
    DONE
  } state_t;

  state_t                  state_q;
  logic [MAX_BYTE_WID-1:0] off_q;
  logic [MAX_BYTE_WID-1:0] off_d;
  logic [RAM_WORD-1:0]     lo_q;
  logic [DAT_WID-1:0]      data_q;
  logic                    fin_q;
  logic                    read_q;
  logic                    ack;

  // next word offset; wraps silently at the counter width
  assign off_d = off_q + STEP;
  assign ack   = read_q && valid;

  assign addr     = BASE_ADDR + RAM_WID'(off_q);
  assign data     = data_q;
  assign finished = fin_q;
  assign read     = read_q;

  // fetch sequencer: low word, one idle cycle, high word, then hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      fin_q   <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rewind) off_q <= '0;
          if (fetch) begin
            read_q  <= 1'b1;
            state_q <= RD_LO;
          end
        end
        RD_LO: begin
          if (ack) begin
            lo_q    <= word;
            off_q   <= off_d;
            read_q  <= 1'b0;
            state_q <= GAP;
          end
        end
        GAP: begin
          read_q  <= 1'b1;
          state_q <= RD_HI;
        end
        RD_HI: begin
          if (ack) begin
            data_q  <= {word[HW-1:0], lo_q};
            off_q   <= off_d;
            read_q  <= 1'b0;
            fin_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!fetch) begin
            fin_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          read_q  <= 1'b0;
          fin_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
